// File: rtl/fc_pkg.sv
// Shared state encoding and width helpers for the streaming fully-connected neuron.
package fc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;

  // Edges spent in DRAIN: product stage, lane-sum stage, accumulate stage.
  localparam int DRAIN_CYCLES = 3;

  function automatic int acc_width(input int width, input int in);
    return 2 * width + $clog2(in);
  endfunction

  function automatic int lane_sum_width(input int width, input int lanes);
    return 2 * width + $clog2(lanes);
  endfunction

endpackage

// File: rtl/fc_lane_dot.sv
// Per-beat dot product across LANES lanes: registered products, then a registered lane sum.
module fc_lane_dot import fc_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  localparam int SW = lane_sum_width(WIDTH, LANES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [LANES*WIDTH-1:0]    x,
  input  logic [LANES*WIDTH-1:0]    w,
  output logic                      out_valid,
  output logic signed [SW-1:0]      sum
);

  localparam int PW = 2 * WIDTH;

  logic signed [PW-1:0] prod_r [LANES];
  logic signed [SW-1:0] tree_s;
  logic signed [SW-1:0] sum_r;
  logic                 valid1_r;
  logic                 valid2_r;

  // Stage 1: signed lane products
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid1_r <= 1'b0;
      for (int j = 0; j < LANES; j++) prod_r[j] <= {PW{1'b0}};
    end else begin
      valid1_r <= in_valid;
      for (int j = 0; j < LANES; j++)
        prod_r[j] <= PW'($signed(x[j*WIDTH +: WIDTH])) * PW'($signed(w[j*WIDTH +: WIDTH]));
    end
  end

  // Sign-extended sum of all lane products
  always_comb begin
    tree_s = {SW{1'b0}};
    for (int j = 0; j < LANES; j++) tree_s = tree_s + SW'(prod_r[j]);
  end

  // Stage 2: registered lane sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid2_r <= 1'b0;
      sum_r    <= {SW{1'b0}};
    end else begin
      valid2_r <= valid1_r;
      sum_r    <= tree_s;
    end
  end

  assign out_valid = valid2_r;
  assign sum       = sum_r;

endmodule

// File: rtl/fc_neuron_stream.sv
// Streaming fully-connected neuron: programmable weights, pipelined lane dot product,
// frame accumulator, optional ReLU and a held output register with backpressure.
module fc_neuron_stream import fc_pkg::*; #(
  parameter int WIDTH   = 8,
  parameter int IN      = 128,
  parameter int LANES   = 4,
  parameter int RELU_EN = 1,
  localparam int ACC_WIDTH = acc_width(WIDTH, IN),
  localparam int AW        = $clog2(IN)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   w_we,
  input  logic [AW-1:0]          w_addr,
  input  logic [WIDTH-1:0]       w_data,
  output logic                   busy,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [LANES*WIDTH-1:0] s_data,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [ACC_WIDTH-1:0]   m_data,
  output logic                   err
);

  localparam int BEATS = IN / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SW    = lane_sum_width(WIDTH, LANES);

  logic signed [WIDTH-1:0]     wmem_r [IN];
  state_e                      state_r;
  logic [BW-1:0]               beat_r;
  logic [1:0]                  drain_r;
  logic signed [ACC_WIDTH-1:0] acc_r;
  logic signed [ACC_WIDTH-1:0] relu_s;
  logic [ACC_WIDTH-1:0]        m_data_r;
  logic                        m_valid_r;
  logic                        s_ready_r;
  logic                        busy_r;
  logic                        err_r;
  logic                        accept_s;
  logic                        last_beat_s;
  logic [LANES*WIDTH-1:0]      w_lanes_s;
  logic                        lane_valid_s;
  logic signed [SW-1:0]        lane_sum_s;

  assign accept_s    = s_valid && s_ready_r;
  assign last_beat_s = (beat_r == BW'(BEATS - 1));

  // Weight register file; deliberately not reset so weights survive rst_n
  always_ff @(posedge clk) begin
    if (w_we && !busy_r) wmem_r[w_addr] <= w_data;
  end

  // Weights for the current beat, one per lane
  always_comb begin
    w_lanes_s = {(LANES*WIDTH){1'b0}};
    for (int j = 0; j < LANES; j++)
      w_lanes_s[j*WIDTH +: WIDTH] = wmem_r[AW'(beat_r) * AW'(LANES) + AW'(j)];
  end

  fc_lane_dot #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_lane_dot (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (accept_s),
    .x         (s_data),
    .w         (w_lanes_s),
    .out_valid (lane_valid_s),
    .sum       (lane_sum_s)
  );

  // Frame accumulator; cleared by the first beat so frames never mix
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {ACC_WIDTH{1'b0}};
    end else if (state_r == IDLE && accept_s) begin
      acc_r <= {ACC_WIDTH{1'b0}};
    end else if (lane_valid_s) begin
      acc_r <= acc_r + ACC_WIDTH'(lane_sum_s);
    end
  end

  // Optional ReLU on the finished sum
  always_comb begin
    if (RELU_EN != 0 && acc_r[ACC_WIDTH-1]) relu_s = {ACC_WIDTH{1'b0}};
    else                                    relu_s = acc_r;
  end

  // Frame FSM, beat counter, framing check and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      beat_r    <= {BW{1'b0}};
      drain_r   <= 2'd0;
      s_ready_r <= 1'b0;
      m_valid_r <= 1'b0;
      m_data_r  <= {ACC_WIDTH{1'b0}};
      busy_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      err_r <= accept_s && (s_last != last_beat_s);
      case (state_r)
        IDLE, ACCUM: begin
          s_ready_r <= 1'b1;
          if (accept_s) begin
            busy_r <= 1'b1;
            if (last_beat_s) begin
              state_r   <= DRAIN;
              beat_r    <= {BW{1'b0}};
              drain_r   <= 2'd0;
              s_ready_r <= 1'b0;
            end else begin
              state_r <= ACCUM;
              beat_r  <= beat_r + BW'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_r == 2'(DRAIN_CYCLES - 1)) begin
            state_r   <= OUT;
            m_valid_r <= 1'b1;
            m_data_r  <= relu_s;
          end else begin
            drain_r <= drain_r + 2'd1;
          end
        end
        OUT: begin
          if (m_ready) begin
            state_r   <= IDLE;
            m_valid_r <= 1'b0;
            s_ready_r <= 1'b1;
            busy_r    <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          s_ready_r <= 1'b0;
          m_valid_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready = s_ready_r;
  assign m_valid = m_valid_r;
  assign m_data  = m_data_r;
  assign busy    = busy_r;
  assign err     = err_r;

endmodule

// File: doc/fc_neuron_stream.md
Name: fc_neuron_stream

Overview:
- Time-multiplexed fully-connected neuron: dot product of an IN-element signed input vector with a runtime-loadable signed weight vector, then optional ReLU.
- Inputs stream in LANES elements per beat over a valid/ready handshake.
- Successor to the fixed-coefficient combinational neuron layer. Weights are programmable, the datapath is pipelined, and one result is produced per frame with output backpressure.

Parameters:
- WIDTH, 8, bit width of each signed input element and each signed weight.
- IN, 128, number of inputs per frame; must be a multiple of LANES.
- LANES, 4, input elements consumed per accepted beat; power of two, 1..16.
- RELU_EN, 1, 1 = negative results clamp to 0; 0 = signed result passes through.
- ACC_WIDTH, 2*WIDTH+$clog2(IN), derived (localparam), width of the accumulator and of the output.

Ports:
- clk  in  1  clock; everything is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- w_we  in  1  weight write strobe.
- w_addr  in  $clog2(IN)  weight index.
- w_data  in  WIDTH  signed weight.
- busy  out  1  high from first accepted beat until the output handshake completes.
- s_valid  in  1  input beat valid.
- s_ready  out  1  block can accept a beat.
- s_data  in  LANES*WIDTH  lane j is at bits [j*WIDTH +: WIDTH] and carries element beat*LANES+j.
- s_last  in  1  producer marks the final beat of a frame.
- m_valid  out  1  result valid.
- m_ready  in  1  consumer accepts the result.
- m_data  out  ACC_WIDTH  result, signed, or non-negative when RELU_EN=1.
- err  out  1  one-cycle pulse on an s_last framing mismatch.

Behaviour:
- Reset values: s_ready=0 while rst_n is low and 1 in the first cycle after release; m_valid=0, m_data=0, busy=0, err=0. Beat counter, pipeline and accumulator are cleared.
- Weight storage is a register file with no reset; contents survive rst_n.
- Weight writes are accepted only while busy=0. A write while busy=1 is dropped silently.
- Accept condition: a beat is accepted when s_valid && s_ready. BEATS = IN/LANES.
- FSM states:
  - IDLE: s_ready=1. First accepted beat goes to ACCUM.
  - ACCUM: s_ready=1. Beat counter increments per accepted beat. Acceptance of beat BEATS-1 goes to DRAIN, and s_ready drops in the next cycle.
  - DRAIN: s_ready=0 while the pipeline flushes. After 3 cycles go to OUT with m_valid=1.
  - OUT: s_ready=0, m_data held stable. m_valid && m_ready goes to IDLE, m_valid falls, and s_ready=1 in the following cycle.
- Pipeline:
  - P1: LANES signed products, each 2*WIDTH bits, registered.
  - P2: lane adder tree, registered; width 2*WIDTH+$clog2(LANES).
  - P3: accumulator, sign-extended to ACC_WIDTH.
- Latency: m_valid is asserted 3 cycles after the edge that accepts the final beat.
- The accumulator clears on entry to ACCUM, so back-to-back frames cannot contaminate each other.
- Arithmetic is two's complement throughout. ACC_WIDTH guarantees no overflow, including IN products of (-2^(WIDTH-1))^2.
- ReLU: with RELU_EN=1, m_data=0 when the accumulator MSB is set. Zero itself passes unchanged.
- Frame boundary is set by the beat count only.
  - s_last on a beat other than BEATS-1 pulses err the cycle after acceptance.
  - s_last low on beat BEATS-1 also pulses err.
  - The frame still completes normally in both cases.
- m_valid never drops without a handshake.
- Reset mid-frame aborts the partial frame. No result is emitted for it.

Decomposition:
- Package fc_pkg:
  - state enum {IDLE, ACCUM, DRAIN, OUT};
  - function acc_width(width, in);
  - function lane_sum_width(width, lanes).
- Sub-module fc_lane_dot:
  - LANES multipliers plus registered adder tree (P1+P2);
  - input valid and output valid, with a 2-cycle latency.
- Top level contains: FSM, beat counter, weight register file, LANES-wide weight read mux indexed by beat, accumulator, ReLU, output register.

Test Plan:
- Basic (IN=8, LANES=4, RELU_EN=1): weights all 1, x=1..8 in 2 beats, m_ready=1 → m_data=36, m_valid 3 cycles after beat 2, err=0.
- Negative result: weights all -2, x all 10. RELU_EN=1 → m_data=0. RELU_EN=0 → m_data=-160 sign-extended to ACC_WIDTH.
- Extremes (IN=128, LANES=4): weights all -128, x all -128 → m_data=2097152 with no overflow. Weights -128 with x=127 and RELU_EN=0 → -2080768.
- Backpressure: hold m_ready=0 for 5 cycles → m_data/m_valid stable, s_ready=0. A second frame sent right after the handshake gives an independent correct sum.
- Framing: s_last on beat 0 of 2 → err pulses once and the result still appears after beat 2. A w_we during busy leaves that weight unchanged in the next frame.
- Reset mid-frame: drop rst_n after 1 beat → m_valid=0 and s_ready=1 after release. A fresh full frame gives the correct sum with weights retained.
